// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver. It has a configurable data width,
//               optional even/odd parity, 1 or 2 stop bits and start-bit glitch
//               rejection. It reports parity and frame errors alongside a
//               single-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int NUM_CLKS_PER_BIT = 16,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_MODE      = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(NUM_CLKS_PER_BIT);
    localparam int BIT_W = 4;

    localparam logic [CNT_W-1:0] c_full_lim   = CNT_W'(NUM_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_lim   = CNT_W'(NUM_CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] c_last_data  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] c_last_stop  = BIT_W'(STOP_BITS - 1);
    localparam logic             c_has_parity = (PARITY_MODE != 0);
    localparam logic             c_odd_parity = (PARITY_MODE == 2);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_parity    = 3'd3;
    localparam logic [2:0] c_st_stop      = 3'd4;
    localparam logic [2:0] c_st_wait_high = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_perr;
    logic                 r_ferr;

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Frame receive FSM. All outputs are registered. The frame is delivered at
    // the middle of the last stop bit, so frames with no idle gap between them
    // are still caught.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            r_clk_cnt    <= r_clk_cnt + 1'b1;
            case (r_state)
                c_st_idle: begin
                    r_clk_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state   <= c_st_start;
                        busy      <= 1'b1;
                        r_bit_cnt <= '0;
                        r_par_acc <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (r_clk_cnt == c_half_lim) begin
                        r_clk_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= c_st_data;
                        end else begin
                            // Line went high again before mid-start-bit, so
                            // treat the low pulse as a glitch.
                            r_state <= c_st_idle;
                            busy    <= 1'b0;
                        end
                    end
                end
                c_st_data: begin
                    if (r_clk_cnt == c_full_lim) begin
                        r_clk_cnt <= '0;
                        // Shift in from the top. After DATA_BITS samples the
                        // first (LSB) bit has reached index 0.
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_rx_s;
                        if (r_bit_cnt == c_last_data) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_has_parity ? c_st_parity : c_st_stop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_st_parity: begin
                    if (r_clk_cnt == c_full_lim) begin
                        r_clk_cnt <= '0;
                        r_perr    <= c_has_parity && ((r_par_acc ^ w_rx_s) != c_odd_parity);
                        r_state   <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (r_clk_cnt == c_full_lim) begin
                        r_clk_cnt <= '0;
                        if (!w_rx_s) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bit_cnt == c_last_stop) begin
                            r_bit_cnt    <= '0;
                            rx_data      <= r_shift;
                            rx_valid     <= 1'b1;
                            parity_error <= r_perr;
                            frame_error  <= r_ferr | ~w_rx_s;
                            if (w_rx_s) begin
                                r_state <= c_st_idle;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= c_st_wait_high;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_st_wait_high: begin
                    // A held-low line (break) must not be taken as a new start bit.
                    r_clk_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= c_st_idle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_clk_cnt <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
